fetch_predict_unit: RTL

FETCH_PREDICT_UNIT -- requirements
Module: fetch_predict_unit

---
 rtl/fetch_predict_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fetch_predict_unit.sv
// Fetch stage with a direct-mapped BTB and 2-bit saturating branch predictor.
// Optional macro FETCH_BTB_EN enables the BTB; without it fetch is strictly sequential.
module fetch_predict_unit #(
    parameter logic [31:0] PC_INIT   = 32'h0000_0000,
    parameter int          BTB_DEPTH = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic [31:0] imemaddr,
    output logic        imemREN,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        halt,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    output logic        fd_valid,
    output logic [31:0] fd_instr,
    output logic [31:0] fd_pc,
    output logic [31:0] fd_npc,
    output logic        fd_pred_taken,
    output logic [31:0] fd_pred_target
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = 30 - IDX_W;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        halted;
    logic        halting;
    logic        pred_taken;
    logic [31:0] pred_target;

    assign pc_plus4 = pc + 32'd4;
    assign imemaddr = pc;
    assign imemREN  = !halted;
    assign halting  = halted | halt;
    assign next_pc  = pred_taken ? pred_target : pc_plus4;

`ifdef FETCH_BTB_EN
    logic [BTB_DEPTH-1:0] btb_valid;
    logic [TAG_W-1:0]     btb_tag    [BTB_DEPTH];
    logic [31:0]          btb_target [BTB_DEPTH];
    logic [1:0]           btb_cnt    [BTB_DEPTH];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_hit;
    logic             unused_upd;

    assign rd_idx = pc[IDX_W+1:2];
    assign rd_tag = pc[31:IDX_W+2];
    assign wr_idx = upd_pc[IDX_W+1:2];
    assign wr_tag = upd_pc[31:IDX_W+2];
    assign wr_hit = btb_valid[wr_idx] && (btb_tag[wr_idx] == wr_tag);

    assign unused_upd = ^upd_pc[1:0];

    // Lookup reads the pre-update array, so a same-cycle write is seen next cycle.
    assign pred_taken  = btb_valid[rd_idx]
                       && (btb_tag[rd_idx] == rd_tag)
                       && btb_cnt[rd_idx][1];
    assign pred_target = pred_taken ? btb_target[rd_idx] : 32'h0;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            btb_valid <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_cnt[i]    <= 2'b00;
                btb_tag[i]    <= '0;
                btb_target[i] <= 32'h0;
            end
        end else if (upd_en) begin
            if (wr_hit) begin
                if (upd_taken) begin
                    if (btb_cnt[wr_idx] != 2'b11) begin
                        btb_cnt[wr_idx] <= btb_cnt[wr_idx] + 2'b01;
                    end
                    btb_target[wr_idx] <= upd_target;
                end else if (btb_cnt[wr_idx] != 2'b00) begin
                    btb_cnt[wr_idx] <= btb_cnt[wr_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                btb_valid[wr_idx]  <= 1'b1;
                btb_tag[wr_idx]    <= wr_tag;
                btb_target[wr_idx] <= upd_target;
                btb_cnt[wr_idx]    <= 2'b10;
            end
        end
    end
`else
    logic unused_upd;

    assign pred_taken  = 1'b0;
    assign pred_target = 32'h0;
    assign unused_upd  = ^{upd_en, upd_pc, upd_target, upd_taken};
`endif

    // Priority: reset, halt (sticky), flush, stall, then fetch or bubble.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            pc             <= PC_INIT;
            halted         <= 1'b0;
            fd_valid       <= 1'b0;
            fd_instr       <= 32'h0;
            fd_pc          <= PC_INIT;
            fd_npc         <= PC_INIT + 32'd4;
            fd_pred_taken  <= 1'b0;
            fd_pred_target <= 32'h0;
        end else if (halting) begin
            halted   <= 1'b1;
            fd_valid <= 1'b0;
        end else if (flush) begin
            pc       <= flush_pc;
            fd_valid <= 1'b0;
        end else if (!stall) begin
            if (ihit) begin
                pc             <= next_pc;
                fd_valid       <= 1'b1;
                fd_instr       <= imemload;
                fd_pc          <= pc;
                fd_npc         <= pc_plus4;
                fd_pred_taken  <= pred_taken;
                fd_pred_target <= pred_target;
            end else begin
                fd_valid <= 1'b0;
            end
        end
    end

endmodule
